v810_ebi_target: RTL and testbench

//  Synthesizable V810 external-bus responder (target side of the v810_mem EBI).

---
 rtl/v810_ebi_target.sv | 124 ++++++++++++
 tb/tb_v810_ebi_target.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/v810_ebi_target.sv
// V810 external-bus target: decodes a T1 cycle, inserts wait states, sizes the
// cycle for 32/16-bit devices and bridges it onto a single-port synchronous SRAM.
module v810_ebi_target #(
    parameter int          WAIT_STATES = 0,
    parameter bit          BUS16       = 1'b0,
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter logic [31:0] MASK        = 32'h8000_0000,
    parameter bit          IO_SPACE    = 1'b0
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 ce,
    input  logic [31:0]          a,
    input  logic [31:0]          d_i,
    output logic [31:0]          d_o,
    input  logic [3:0]           be_n,
    input  logic [1:0]           st,
    input  logic                 da_n,
    input  logic                 mrq_n,
    input  logic                 rw,
    input  logic                 bcyst_n,
    output logic                 ready_n,
    output logic                 szrq_n,
    output logic [ADDR_BITS-1:0] mem_a,
    output logic                 mem_ce_n,
    output logic                 mem_we_n,
    output logic [3:0]           mem_be_n,
    output logic [31:0]          mem_di,
    input  logic [31:0]          mem_do,
    output logic                 perr
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [ADDR_BITS-1:0] idx_l;
    logic                 rw_l;
    logic [3:0]           be_l;
    logic                 hit, req, sel, complete, start, strobe_busy;
    logic                 wr_go, rd_live, rd_hold;
    logic [15:0]          half;
    logic [1:0]           pair;

    function automatic logic [ADDR_BITS-1:0] entry(input logic [31:0] addr);
        return BUS16 ? addr[ADDR_BITS:1] : addr[ADDR_BITS+1:2];
    endfunction

    assign hit         = (a & MASK) == BASE;
    assign req         = IO_SPACE ? (mrq_n & (st == 2'b10)) : ~mrq_n;
    assign sel         = ce & ~bcyst_n & hit & req;
    assign complete    = ce & ~res & (state == S_ACK) & ~da_n;
    assign start       = sel & ((state == S_IDLE) | complete);
    assign strobe_busy = ce & ~bcyst_n & ((state == S_WAIT) | ((state == S_ACK) & da_n));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_WAIT: if (ce) begin
                if (cnt == 4'd1) state_nxt = S_ACK;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_ACK:   if (complete) state_nxt = S_IDLE;
            default: ;
        endcase
        // A start in the completing ACK cycle chains the next cycle with no idle gap.
        if (start) begin
            state_nxt = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            cnt_nxt   = WS_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            perr  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (strobe_busy) perr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            idx_l <= entry(a);
            rw_l  <= rw;
            be_l  <= be_n;
        end
    end

    // Reads keep the SRAM enabled through WAIT/ACK so data tracks the one-cycle
    // read latency; a completing write owns the port over a chained read start.
    assign wr_go    = complete & ~rw_l;
    assign rd_live  = start & rw;
    assign rd_hold  = ((state == S_WAIT) | (state == S_ACK)) & rw_l;
    assign ready_n  = ~complete;
    assign szrq_n   = BUS16 ? ready_n : 1'b1;
    assign mem_we_n = ~wr_go;
    assign mem_ce_n = ~(wr_go | rd_live | rd_hold);
    assign mem_a    = (rd_live & ~wr_go) ? entry(a) : idx_l;
    assign d_o      = ((state == S_ACK) & rw_l) ?
                      (BUS16 ? {mem_do[15:0], mem_do[15:0]} : mem_do) : 32'h0;

    assign half = (be_l[1:0] != 2'b11) ? d_i[15:0] : d_i[31:16];
    assign pair = (be_l[1:0] != 2'b11) ? be_l[1:0] : be_l[3:2];

    always_comb begin
        mem_di   = 32'h0;
        mem_be_n = 4'hF;
        if (wr_go) begin
            if (BUS16) begin
                mem_di   = {16'h0, half};
                mem_be_n = {2'b11, pair};
            end else begin
                mem_di   = d_i;
                mem_be_n = be_l;
            end
        end
    end
endmodule

// File: tb/tb_v810_ebi_target.sv
// Bench for v810_ebi_target: three targets (WS=0/32-bit, WS=2/32-bit, WS=1/16-bit)
// on a shared bus, each with its own SRAM, checked against a word-level memory model.
module tb_v810_ebi_target;
    localparam int N  = 3;
    localparam int AB = 10;

    function automatic int ws_of(input int u);
        return (u == 0) ? 0 : ((u == 1) ? 2 : 1);
    endfunction
    function automatic bit b16_of(input int u);
        return u == 2;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           res;
    logic [N-1:0]   ce_v;
    logic [31:0]    a, d_i;
    logic [3:0]     be_n;
    logic [1:0]     st;
    logic           da_n, mrq_n, rw, bcyst_n;
    logic [31:0]    d_o [N];
    logic [N-1:0]   ready_n, szrq_n, mem_ce_n, mem_we_n, perr;
    logic [AB-1:0]  mem_a [N];
    logic [3:0]     mem_be_n [N];
    logic [31:0]    mem_di [N];
    logic [31:0]    mem_do [N];
    logic [31:0]    sram [N][1<<AB];
    logic [31:0]    exp_mem [N][1<<AB];

    for (genvar g = 0; g < N; g++) begin : g_dut
        v810_ebi_target #(
            .WAIT_STATES(ws_of(g)), .BUS16(b16_of(g)), .ADDR_BITS(AB),
            .BASE(32'h8000_0000), .MASK(32'h8000_0000), .IO_SPACE(1'b0)
        ) dut (
            .clk(clk), .res(res), .ce(ce_v[g]), .a(a), .d_i(d_i), .d_o(d_o[g]),
            .be_n(be_n), .st(st), .da_n(da_n), .mrq_n(mrq_n), .rw(rw), .bcyst_n(bcyst_n),
            .ready_n(ready_n[g]), .szrq_n(szrq_n[g]), .mem_a(mem_a[g]),
            .mem_ce_n(mem_ce_n[g]), .mem_we_n(mem_we_n[g]), .mem_be_n(mem_be_n[g]),
            .mem_di(mem_di[g]), .mem_do(mem_do[g]), .perr(perr[g])
        );
    end

    // Synchronous SRAMs with one-cycle read latency.
    always @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (!mem_ce_n[j]) begin
                if (!mem_we_n[j]) begin
                    for (int b = 0; b < 4; b++)
                        if (!mem_be_n[j][b]) sram[j][mem_a[j]][8*b +: 8] <= mem_di[j][8*b +: 8];
                end else begin
                    mem_do[j] <= sram[j][mem_a[j]];
                end
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int index_of(input int u, input logic [31:0] addr);
        return b16_of(u) ? int'(addr[AB:1]) : int'(addr[AB+1:2]);
    endfunction

    function automatic void model_write(input int u, input logic [31:0] addr,
                                        input logic [3:0] be, input logic [31:0] data);
        int i;
        logic [15:0] hv;
        logic [1:0]  pr;
        i = index_of(u, addr);
        if (b16_of(u)) begin
            hv = (be[1:0] != 2'b11) ? data[15:0] : data[31:16];
            pr = (be[1:0] != 2'b11) ? be[1:0]    : be[3:2];
            if (!pr[0]) exp_mem[u][i][7:0]  = hv[7:0];
            if (!pr[1]) exp_mem[u][i][15:8] = hv[15:8];
        end else begin
            for (int b = 0; b < 4; b++)
                if (!be[b]) exp_mem[u][i][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input int u, input logic [31:0] addr);
        logic [31:0] w;
        w = exp_mem[u][index_of(u, addr)];
        return b16_of(u) ? {w[15:0], w[15:0]} : w;
    endfunction

    logic [31:0] rd, wdi;
    logic [3:0]  wbe;
    int          lat, wec, wat;

    // One complete bus cycle on target u; DAn is held off for dly cycles after T1.
    task automatic bus_cycle(input int u, input logic [31:0] addr, input logic wr,
                             input logic [3:0] be, input logic [31:0] data, input int dly,
                             output logic [31:0] rdata, output int lt, output int we_cnt,
                             output int we_at, output logic [3:0] w_be, output logic [31:0] w_di);
        int exp_lat;
        exp_lat = 1 + ((ws_of(u) > dly) ? ws_of(u) : dly);
        ce_v = '0;
        ce_v[u] = 1'b1;
        lt = -1; we_cnt = 0; we_at = -1; rdata = 32'h0; w_be = 4'hF; w_di = 32'h0;
        @(posedge clk); #1;
        a = addr; rw = ~wr; be_n = be; d_i = data; mrq_n = 1'b0; st = 2'b00;
        bcyst_n = 1'b0; da_n = 1'b1;
        for (int c = 0; c < 40 && lt < 0; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                bcyst_n = 1'b1;
                da_n = (c > dly) ? 1'b0 : 1'b1;
            end
            @(negedge clk);
            if (!mem_we_n[u]) begin
                we_cnt++; we_at = c; w_be = mem_be_n[u]; w_di = mem_di[u];
            end
            if (!ready_n[u]) begin
                lt = c;
                rdata = d_o[u];
                check("szrq", 32'(szrq_n[u]), b16_of(u) ? 32'h0 : 32'h1);
            end
        end
        check("latency", 32'(lt), 32'(exp_lat));
        if (wr) begin
            check("we_count", 32'(we_cnt), 32'h1);
            check("we_cycle", 32'(we_at), 32'(exp_lat));
            model_write(u, addr, be, data);
        end else begin
            check("we_count", 32'(we_cnt), 32'h0);
            check("rdata", rdata, model_read(u, addr));
        end
        @(posedge clk); #1;
        da_n = 1'b1; bcyst_n = 1'b1;
        @(negedge clk);
        check("ready_single", 32'(ready_n[u]), 32'h1);
        check("perr", 32'(perr[u]), 32'h0);
    endtask

    task automatic watch_idle(input int u, input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check(tag, 32'({ready_n[u], mem_ce_n[u]}), 32'h3);
            @(posedge clk); #1;
            bcyst_n = 1'b1; da_n = 1'b0;
        end
        da_n = 1'b1;
    endtask

    initial begin
        res = 1'b1; ce_v = '1; a = 32'h0; d_i = 32'h0; be_n = 4'hF; st = 2'b00;
        da_n = 1'b1; mrq_n = 1'b1; rw = 1'b1; bcyst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        @(negedge clk);
        for (int u = 0; u < N; u++) begin
            check("rst_ready", 32'(ready_n[u]), 32'h1);
            check("rst_szrq", 32'(szrq_n[u]), 32'h1);
            check("rst_do", d_o[u], 32'h0);
            check("rst_ce", 32'(mem_ce_n[u]), 32'h1);
            check("rst_we", 32'(mem_we_n[u]), 32'h1);
            check("rst_be", 32'(mem_be_n[u]), 32'hF);
            check("rst_perr", 32'(perr[u]), 32'h0);
        end

        // WS=0 read after preloading entry 4
        bus_cycle(0, 32'h8000_0010, 1'b1, 4'h0, 32'h1234_5678, 0, rd, lat, wec, wat, wbe, wdi);
        bus_cycle(0, 32'h8000_0010, 1'b0, 4'h0, 32'h0, 0, rd, lat, wec, wat, wbe, wdi);
        check("t1_lat", 32'(lat), 32'h1);
        check("t1_do", rd, 32'h1234_5678);

        // WS=2 write with partial byte enables
        bus_cycle(1, 32'h8000_0020, 1'b1, 4'b1100, 32'hCAFE_BABE, 0, rd, lat, wec, wat, wbe, wdi);
        check("t2_we_at", 32'(wat), 32'h3);
        check("t2_be", 32'(wbe), 32'hC);
        check("t2_di", wdi, 32'hCAFE_BABE);
        check("t2_sram", 32'(sram[1][8][15:0]), 32'hBABE);

        // 16-bit device: halves steered by byte enables, read data replicated
        bus_cycle(2, 32'h8000_0008, 1'b1, 4'b1100, 32'h0000_5678, 0, rd, lat, wec, wat, wbe, wdi);
        check("t3_di_lo", wdi, 32'h0000_5678);
        bus_cycle(2, 32'h8000_000A, 1'b1, 4'b0011, 32'h1234_0000, 0, rd, lat, wec, wat, wbe, wdi);
        check("t3_di_hi", wdi, 32'h0000_1234);
        check("t3_be_hi", 32'(wbe), 32'hC);
        bus_cycle(2, 32'h8000_0008, 1'b0, 4'h0, 32'h0, 0, rd, lat, wec, wat, wbe, wdi);
        check("t3_do_lo", rd, 32'h5678_5678);
        bus_cycle(2, 32'h8000_000A, 1'b0, 4'h0, 32'h0, 0, rd, lat, wec, wat, wbe, wdi);
        check("t3_do_hi", rd, 32'h1234_1234);

        // Back-to-back reads chained in the completing ACK cycle
        bus_cycle(0, 32'h8000_0014, 1'b1, 4'h0, 32'hA5A5_0F0F, 0, rd, lat, wec, wat, wbe, wdi);
        ce_v = 3'b001;
        @(posedge clk); #1;
        a = 32'h8000_0010; rw = 1'b1; be_n = 4'h0; mrq_n = 1'b0; st = 2'b00;
        bcyst_n = 1'b0; da_n = 1'b1;
        @(negedge clk);
        check("t4_t1_ready", 32'(ready_n[0]), 32'h1);
        @(posedge clk); #1;
        a = 32'h8000_0014; bcyst_n = 1'b0; da_n = 1'b0;
        @(negedge clk);
        check("t4_ready1", 32'(ready_n[0]), 32'h0);
        check("t4_do1", d_o[0], 32'h1234_5678);
        @(posedge clk); #1;
        bcyst_n = 1'b1;
        @(negedge clk);
        check("t4_ready2", 32'(ready_n[0]), 32'h0);
        check("t4_do2", d_o[0], 32'hA5A5_0F0F);
        @(posedge clk); #1;
        da_n = 1'b1;
        @(negedge clk);
        check("t4_ready_end", 32'(ready_n[0]), 32'h1);
        check("t4_perr", 32'(perr[0]), 32'h0);

        // Halt/fault acknowledge and out-of-range address are never selected
        @(posedge clk); #1;
        a = 32'h8000_0010; rw = 1'b1; mrq_n = 1'b1; st = 2'b11; bcyst_n = 1'b0;
        watch_idle(0, 4, "t5_halt");
        a = 32'h0000_0010; mrq_n = 1'b0; st = 2'b00; bcyst_n = 1'b0;
        watch_idle(0, 4, "t5_nohit");

        // Randomised traffic over a 16-entry window on every target
        for (int u = 0; u < N; u++)
            for (int i = 0; i < 16; i++)
                bus_cycle(u, 32'h8000_0000 + (b16_of(u) ? 2*i : 4*i), 1'b1,
                          b16_of(u) ? 4'b1100 : 4'h0, $urandom, 0, rd, lat, wec, wat, wbe, wdi);
        for (int k = 0; k < 60; k++) begin
            int u, i;
            logic [31:0] addr;
            u = $urandom_range(0, N-1);
            i = $urandom_range(0, 15);
            addr = 32'h8000_0000 | ($urandom & 32'h7FFF_F000) | (b16_of(u) ? 2*i : 4*i);
            bus_cycle(u, addr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                      $urandom_range(0, 3), rd, lat, wec, wat, wbe, wdi);
        end

        // Protocol error in WAIT, then reset aborts the write before ACK
        bus_cycle(1, 32'h8000_0040, 1'b1, 4'h0, 32'h1111_2222, 0, rd, lat, wec, wat, wbe, wdi);
        ce_v = 3'b010;
        @(posedge clk); #1;
        a = 32'h8000_0040; rw = 1'b0; be_n = 4'h0; d_i = 32'hDEAD_BEEF; mrq_n = 1'b0;
        st = 2'b00; bcyst_n = 1'b0; da_n = 1'b1;
        @(posedge clk); #1;
        bcyst_n = 1'b0; da_n = 1'b0;
        @(posedge clk); #1;
        bcyst_n = 1'b1; res = 1'b1;
        @(negedge clk);
        check("t6_perr_set", 32'(perr[1]), 32'h1);
        check("t6_we_wait", 32'(mem_we_n[1]), 32'h1);
        @(posedge clk); #1;
        res = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t6_ready", 32'(ready_n[1]), 32'h1);
            check("t6_we", 32'(mem_we_n[1]), 32'h1);
            @(posedge clk); #1;
        end
        check("t6_perr_clr", 32'(perr[1]), 32'h0);
        check("t6_sram", sram[1][16], 32'h1111_2222);
        da_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
